keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 hex matrix keypad on the Pmod header by driving one column low at a time and sensing the four rows. Rows are synchronized and debounced across full scans, and each distinct key press becomes a one-cycle `key_valid` pulse with a 4-bit hex code. Accepted codes are shifted into a 16-bit, 4-digit entry register. That register is the input-side counterpart of the 4-digit seven-segment display path: `digits` feeds the display's hex-number input in place of the switches.

## Interface
- `SCAN_DIV`, default 100000: clocks per column slot (1 ms at 100 MHz). Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 8: consecutive identical full scans needed to accept a press or a release. Range 1–255.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous reset, active-low. Release is synchronous to `clk`.
- `row` input, 4 bits: keypad rows, active-low (pulled up). Asynchronous to `clk`.
- `col` output, 4 bits: keypad columns, one-cold. The active column is driven 0.
- `clr` input, 1 bit: synchronous clear of `digits`.
- `key_valid` output, 1 bit: one-cycle pulse when a debounced press is accepted.
- `key_code` output, 4 bits: hex code of the last accepted key. Held between pulses.
- `key_held` output, 1 bit: high from acceptance until the release is debounced.
- `digits` output, 16 bits: entry register. The newest key is in `[3:0]`; older digits shift toward `[15:12]`.

## Operation
- Key map by [row r, column c] gives the hex code:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Synchronizer: `row` passes through two flops before any use.
- Column scan:
  - A slot counter runs 0..SCAN_DIV-1. The column index runs 0..3 and wraps 3→0.
  - `col` = ~(1 << index).
  - On the last cycle of each slot (counter = SCAN_DIV-1), the synchronized rows for that column are sampled into a per-scan accumulator.
  - After column 3 is sampled, the scan result is classified:
    - NONE: no row low in any column.
    - ONE(code): exactly one row/column intersection low.
    - MULTI: two or more intersections low.
  - The accumulator then clears for the next scan.
- Debounce FSM, evaluated once per scan result; `cnt` is 8 bits:
  - IDLE:
    - ONE(k) → cand=k, cnt=1, go to PRESS_WAIT. If DEBOUNCE_SCANS=1, accept immediately.
    - NONE or MULTI → stay in IDLE.
  - PRESS_WAIT:
    - ONE(cand) → cnt+1. When cnt reaches DEBOUNCE_SCANS, accept the key and go to HELD.
    - ONE(other), NONE or MULTI → go to IDLE.
  - HELD:
    - NONE → cnt=1, go to RELEASE_WAIT.
    - ONE or MULTI → stay in HELD. No second accept: there is no auto-repeat.
  - RELEASE_WAIT:
    - NONE → cnt+1. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - ONE or MULTI → go to HELD.
- Accept does all of the following:
  - `key_valid`=1 for exactly one cycle.
  - `key_code`=cand.
  - `digits` = {digits[11:0], cand}. The top digit is discarded.
- `key_held` = 1 in HELD and RELEASE_WAIT, 0 otherwise.
- `clr`: `digits` goes to 0 the next cycle. It does not affect the FSM, `key_code` or the scan.
  - If `clr` and an accept occur in the same cycle, `clr` wins for `digits` (result 0). `key_valid` and `key_code` still update.

## Timing
- Reset values:
  - `col`=4'b1110, scan index 0, slot counter 0.
  - FSM in IDLE, cnt=0, synchronizer flops=4'b1111.
  - `key_valid`=0, `key_code`=0, `key_held`=0, `digits`=0.
- Reset mid-press: all state returns to reset values immediately. A key still held after release of reset must be re-debounced from IDLE.
- Scan period is 4·SCAN_DIV clocks. A row change needs at least 3 clocks to reach a sample, so SCAN_DIV ≥ 4 guarantees settling.
- Accept latency: `key_valid` is high on the cycle after the column-3 sample of the DEBOUNCE_SCANS-th consecutive matching scan. `key_code`, `digits` and `key_held` change on that same cycle.
- The minimum press-to-press interval is set by release debounce. A press that starts during RELEASE_WAIT is not counted.

## Test plan
All scenarios use SCAN_DIV=8 and DEBOUNCE_SCANS=3; one scan is 32 clocks.
- Reset:
  - Stimulus: hold `rst_n`=0, then release.
  - Response: `col`=1110, `digits`=0000, `key_valid`=0. `col` then cycles 1110→1101→1011→0111 every 8 clocks and wraps.
- Clean press:
  - Stimulus: key "5" (row1 low while col1 is low), starting from a scan boundary.
  - Response: exactly one `key_valid` pulse at the end of scan 3, `key_code`=5, `digits`=0x0005, `key_held`=1.
  - Release: `key_held` falls after 3 empty scans.
- Entry and clear:
  - Stimulus: press and release keys 1, A, 3, F, 7 in turn.
  - Response: `digits`=0xA3F7.
  - Then `clr` with the last accept in the same cycle: `digits`=0x0000, `key_code`=7.
- Bounce:
  - Stimulus: "9" present for 2 scans, absent for 1, present for 3.
  - Response: a single pulse, `key_code`=9, after the second run's third scan. A held key gives no repeat.
- Multi-key:
  - Stimulus: "1" and "2" pressed together for 5 scans.
  - Response: no `key_valid`.
  - Then hold "1" alone for 3 scans: one pulse with code 1.
- Reset mid-debounce:
  - Stimulus: assert `rst_n`=0 during PRESS_WAIT for "4".
  - Response: outputs are at reset values immediately. After release of reset with "4" still held, the accept comes 3 full scans later.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 hex keypad column scanner with per-scan debounce.
// Drives one column low per slot, accumulates the synchronized rows over a
// full scan, classifies the scan, and debounces press/release across scans.
// Accepted keys pulse key_valid and shift into a 4-digit entry register.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  input  logic        clr,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam int            CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [7:0]    DEB       = 8'(DEBOUNCE_SCANS);

  // Hex code per intersection, indexed by row*4 + column.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
  typedef enum logic [1:0] {SCAN_NONE, SCAN_ONE, SCAN_MULTI} scan_t;

  logic [3:0]    row_meta, row_sync;
  logic [CW-1:0] slot_q;
  logic [1:0]    col_idx;
  logic [15:0]   acc_q, acc_now;
  logic          slot_last, scan_end;
  logic [1:0]    hit_cnt;
  logic [3:0]    hit_code;
  scan_t         scan_class;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d, cnt_inc;
  logic [3:0]    cand_q, cand_d;
  logic          accept;

  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic [15:0]   digits_q;

  assign slot_last = (slot_q == SLOT_LAST);
  assign scan_end  = slot_last && (col_idx == 2'd3);
  assign cnt_inc   = cnt_q + 8'd1;

  // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // One-cold column drive from the current column index.
  always_comb begin
    col = ~(4'b0001 << col_idx);
  end

  // Merge the current column's pressed rows into the scan accumulator.
  always_comb begin
    acc_now = acc_q;
    for (int unsigned c = 0; c < 4; c++) begin
      if (col_idx == 2'(c)) begin
        for (int unsigned r = 0; r < 4; r++) begin
          if (!row_sync[r]) acc_now[4*r + c] = 1'b1;
        end
      end
    end
  end

  // Classify a full scan: count intersections (saturating at 2) and pick the code.
  always_comb begin
    hit_cnt  = 2'd0;
    hit_code = 4'h0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (acc_now[i]) begin
        if (hit_cnt != 2'd2) hit_cnt = hit_cnt + 2'd1;
        hit_code = KEY_MAP[i];
      end
    end
    case (hit_cnt)
      2'd0:    scan_class = SCAN_NONE;
      2'd1:    scan_class = SCAN_ONE;
      default: scan_class = SCAN_MULTI;
    endcase
  end

  // Slot counter, column index and per-scan accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q  <= '0;
      col_idx <= 2'd0;
      acc_q   <= '0;
    end else if (slot_last) begin
      slot_q  <= '0;
      col_idx <= col_idx + 2'd1;
      acc_q   <= scan_end ? '0 : acc_now;
    end else begin
      slot_q  <= slot_q + CW'(1);
    end
  end

  // Debounce FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  // Debounce FSM next state, evaluated only when a scan completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (scan_class == SCAN_ONE) begin
            cand_d = hit_code;
            cnt_d  = 8'd1;
            if (DEB <= 8'd1) begin
              accept  = 1'b1;
              state_d = HELD;
            end else begin
              state_d = PRESS_WAIT;
            end
          end
        end
        PRESS_WAIT: begin
          if (scan_class == SCAN_ONE && hit_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (scan_class == SCAN_NONE) begin
            cnt_d   = 8'd1;
            state_d = (DEB <= 8'd1) ? IDLE : RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (scan_class == SCAN_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Accept outputs and entry register; clr overrides the shift into digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      digits_q    <= '0;
    end else begin
      key_valid_q <= accept;
      if (accept) key_code_q <= cand_d;
      if (clr)         digits_q <= '0;
      else if (accept) digits_q <= {digits_q[11:0], cand_d};
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digits    = digits_q;
  assign key_held  = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule
